// File: rtl/encoder_4_2_pending_if.sv
// rtl/encoder_4_2_pending_if.sv - request/handshake bundle for the pending priority encoder
interface encoder_4_2_pending_if #(
    parameter int N      = 4,
    parameter int CODE_W = 2
);
    logic              enable;
    logic [N-1:0]      req;
    logic              ready;
    logic [CODE_W-1:0] code_out;
    logic              valid;
    logic              multi;
    logic [N-1:0]      pending;

    // request sources and the consumer of code_out
    modport master (
        output enable,
        output req,
        output ready,
        input  code_out,
        input  valid,
        input  multi,
        input  pending
    );

    // the encoder itself
    modport slave (
        input  enable,
        input  req,
        input  ready,
        output code_out,
        output valid,
        output multi,
        output pending
    );
endinterface

// File: rtl/encoder_4_2_pending.sv
// rtl/encoder_4_2_pending.sv - sticky-pending priority encoder with valid/ready output
module encoder_4_2_pending #(
    parameter int N      = 4,
    parameter int CODE_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    encoder_4_2_pending_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic                r_multi;
    logic                w_multi_nxt;
    logic [N-1:0]        r_pending;
    logic [N-1:0]        w_pending_nxt;

    logic [N-1:0]        w_cap;
    logic                w_cap_any;
    logic                w_cap_multi;
    logic [CODE_W-1:0]   w_sel_idx;
    logic [N-1:0]        w_sel_mask;
    logic                w_load;

    // everything that could be selected on this edge: old pending plus newly enabled requests
    always_comb begin
        w_cap       = r_pending | (bus.enable ? bus.req : '0);
        w_cap_any   = |w_cap;
        // clearing the lowest set bit leaves something only if two or more were set
        w_cap_multi = |(w_cap & (w_cap - N'(1)));
    end

    // highest set index wins; later iterations overwrite earlier ones
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cap[i]) begin
                w_sel_idx = CODE_W'(i);
            end
        end
        w_sel_mask = N'(1) << w_sel_idx;
    end

    // next state: load a new selection whenever the output slot is free or being freed
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_multi_nxt   = r_multi;
        w_pending_nxt = w_cap;
        w_load        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_cap_any) begin
                    w_load = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.ready) begin
                    if (w_cap_any) begin
                        w_load = 1'b1;
                    end else begin
                        // code_out and multi keep their last values while idle
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt   = S_HOLD;
            w_code_nxt    = w_sel_idx;
            w_multi_nxt   = w_cap_multi;
            // the selected request is consumed, even if its req line is high this edge
            w_pending_nxt = w_cap & ~w_sel_mask;
        end
    end

    // state and output registers; reset drops everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_code    <= '0;
            r_multi   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_multi   <= w_multi_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign bus.code_out = r_code;
    assign bus.multi    = r_multi;
    assign bus.pending  = r_pending;
    assign bus.valid    = (r_state == S_HOLD);

endmodule

// File: tb/tb_encoder_4_2_pending.sv
// tb/tb_encoder_4_2_pending.sv - scoreboard bench for encoder_4_2_pending
module tb_encoder_4_2_pending;

    logic clk;
    logic rst_n;

    encoder_4_2_pending_if #(.N(4), .CODE_W(2)) bus ();

    encoder_4_2_pending #(.N(4), .CODE_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // reference model: {multi, code} entries pushed when a selection is made
    logic [2:0] sb_q[$];
    logic       m_valid;
    logic [3:0] m_pending;
    logic [3:0] m_cap;
    logic [1:0] m_sel;
    logic       m_found;

    always_comb begin
        m_cap   = m_pending | (bus.enable ? bus.req : 4'b0000);
        m_sel   = 2'd0;
        m_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (m_cap[i] && !m_found) begin
                m_sel   = 2'(i);
                m_found = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_pending <= 4'b0000;
            sb_q.delete();
        end else if ((!m_valid || bus.ready) && m_cap != 4'b0000) begin
            sb_q.push_back({($countones(m_cap) > 1), m_sel});
            m_valid   <= 1'b1;
            m_pending <= m_cap & ~(4'b0001 << m_sel);
        end else begin
            if (m_valid && bus.ready) m_valid <= 1'b0;
            m_pending <= m_cap;
        end
    end

    // monitor: compare status every cycle, pop the scoreboard on each new presentation
    logic       mon_prev_valid;
    logic       mon_prev_ready;
    logic [2:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_valid = 1'b0;
            mon_prev_ready = 1'b0;
        end else begin
            check("valid", 32'(bus.valid), 32'(m_valid));
            check("pending", 32'(bus.pending), 32'(m_pending));
            if (bus.valid && (!mon_prev_valid || mon_prev_ready)) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(0), 32'(1));
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("sb_code", 32'(bus.code_out), 32'(mon_exp[1:0]));
                    check("sb_multi", 32'(bus.multi), 32'(mon_exp[2]));
                end
            end
            mon_prev_valid = bus.valid;
            mon_prev_ready = bus.ready;
        end
    end

    task automatic cyc(input logic en, input logic [3:0] rq, input logic rd);
        bus.enable = en;
        bus.req    = rq;
        bus.ready  = rd;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] c,
                              input logic m, input logic [3:0] p);
        check({tag, "_valid"}, 32'(bus.valid), 32'(v));
        if (v) begin
            check({tag, "_code"}, 32'(bus.code_out), 32'(c));
            check({tag, "_multi"}, 32'(bus.multi), 32'(m));
        end
        check({tag, "_pending"}, 32'(bus.pending), 32'(p));
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.enable = 1'b1;
        bus.req    = 4'b1111;
        bus.ready  = 1'b0;

        // reset held with all requests active
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_valid", 32'(bus.valid), 32'(0));
            check("rst_code", 32'(bus.code_out), 32'(0));
            check("rst_multi", 32'(bus.multi), 32'(0));
            check("rst_pending", 32'(bus.pending), 32'(0));
        end
        @(posedge clk);
        #2;
        bus.enable = 1'b0;
        bus.req    = 4'b0000;
        rst_n      = 1'b1;
        cyc(1'b1, 4'b0000, 1'b0);
        expect_out("post_rst", 1'b0, 2'd0, 1'b0, 4'b0000);

        // single request, one-cycle latency, then accept
        cyc(1'b1, 4'b0100, 1'b0);
        expect_out("t2_sel", 1'b1, 2'd2, 1'b0, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t2_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // multiple requests drained back-to-back
        cyc(1'b1, 4'b1011, 1'b1);
        expect_out("t3_a", 1'b1, 2'd3, 1'b1, 4'b0011);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t3_b", 1'b1, 2'd1, 1'b1, 4'b0001);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t3_c", 1'b1, 2'd0, 1'b0, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t3_idle", 1'b0, 2'd0, 1'b0, 4'b0000);

        // enable gating
        repeat (5) begin
            cyc(1'b0, 4'b1111, 1'b0);
            expect_out("t4_gated", 1'b0, 2'd0, 1'b0, 4'b0000);
        end
        cyc(1'b1, 4'b1111, 1'b0);
        expect_out("t4_cap", 1'b1, 2'd3, 1'b1, 4'b0111);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t4_d2", 1'b1, 2'd2, 1'b1, 4'b0011);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t4_d1", 1'b1, 2'd1, 1'b1, 4'b0001);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t4_d0", 1'b1, 2'd0, 1'b0, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t4_idle", 1'b0, 2'd0, 1'b0, 4'b0000);

        // higher request arrives while a lower one is held
        cyc(1'b1, 4'b0001, 1'b0);
        expect_out("t5_hold", 1'b1, 2'd0, 1'b0, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0);
        expect_out("t5_stable", 1'b1, 2'd0, 1'b0, 4'b1000);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t5_next", 1'b1, 2'd3, 1'b0, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1);
        expect_out("t5_idle", 1'b0, 2'd0, 1'b0, 4'b0000);

        // asynchronous reset mid-cycle while holding
        cyc(1'b1, 4'b1110, 1'b0);
        expect_out("t6_hold", 1'b1, 2'd3, 1'b1, 4'b0110);
        bus.enable = 1'b1;
        bus.req    = 4'b0000;
        bus.ready  = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.valid), 32'(0));
        check("t6_async_pending", 32'(bus.pending), 32'(0));
        check("t6_async_code", 32'(bus.code_out), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            cyc(1'b1, 4'b0000, 1'b1);
            expect_out("t6_after", 1'b0, 2'd0, 1'b0, 4'b0000);
        end

        // random traffic against the model
        repeat (300) begin
            cyc(1'($urandom_range(0, 3) != 0),
                4'($urandom) & 4'($urandom),
                1'($urandom_range(0, 2) != 0));
        end
        repeat (10) cyc(1'b0, 4'b0000, 1'b1);
        check("drain_valid", 32'(bus.valid), 32'(0));
        check("drain_queue", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
